// File: rtl/mem_responder_if.sv
// Bus bundle for the single-cycle req/ack memory protocol.
// The initiator drives the request side and the responder drives the ack side.
interface mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_read;
    logic              mem_write;
    logic [7:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              mem_err;
    logic [DATA_W-1:0] mem_data;
    logic              mem_busy;

    modport master (
        output mem_req, mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_ack, mem_err, mem_data, mem_busy
    );

    modport slave (
        input  mem_req, mem_read, mem_write, mem_addr, mem_wdata,
        output mem_ack, mem_err, mem_data, mem_busy
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: 256-word array with per-word valid bits that answers
// each accepted request with one ack after an address-dependent latency.
module mem_responder #(
    parameter int FAST_LAT = 2,
    parameter int SLOW_LAT = 9,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  aresetn,
    mem_responder_if.slave        bus,
    output logic [7:0]            drop_cnt
);

    if (FAST_LAT < 1 || FAST_LAT > 5 || SLOW_LAT < 1 || SLOW_LAT > 15) begin : g_bad_latency
        $fatal(1, "mem_responder: FAST_LAT must be 1..5 and SLOW_LAT 1..15");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, next_state;
    logic [3:0]        cnt;
    logic              cmd_read, cmd_write;
    logic [7:0]        addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack_q, err_q;
    logic [DATA_W-1:0] data_q;
    logic [255:0]      valid;
    logic [DATA_W-1:0] mem [256];

    logic              accept, fire, drop;
    logic              f_read, f_write, f_wr_only, f_rd_only;
    logic [7:0]        f_addr;
    logic [DATA_W-1:0] f_wdata;
    logic [3:0]        lat_sel;

    // With a latency of one the ack is issued on the accept edge itself, so the
    // command is taken straight from the bus instead of the latched copy.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        fire       = 1'b0;
        drop       = 1'b0;
        f_read     = cmd_read;
        f_write    = cmd_write;
        f_addr     = addr_q;
        f_wdata    = wdata_q;
        lat_sel    = (bus.mem_addr < 8'd64) ? 4'(FAST_LAT) : 4'(SLOW_LAT);
        case (state)
            IDLE: begin
                if (bus.mem_req) begin
                    accept     = 1'b1;
                    next_state = BUSY;
                    f_read     = bus.mem_read;
                    f_write    = bus.mem_write;
                    f_addr     = bus.mem_addr;
                    f_wdata    = bus.mem_wdata;
                    fire       = (lat_sel == 4'd1);
                end
            end
            BUSY: begin
                drop = bus.mem_req;
                if (ack_q) begin
                    next_state = IDLE;
                end else begin
                    fire = (cnt == 4'd0);
                end
            end
            default: next_state = IDLE;
        endcase
        f_wr_only = f_write && !f_read;
        f_rd_only = f_read && !f_write;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The countdown starts at LAT-2 so that the ack is registered on edge T+LAT-1
    // and is therefore visible when edge T+LAT samples it.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt       <= 4'd0;
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
            addr_q    <= 8'd0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
            valid     <= '0;
            drop_cnt  <= 8'd0;
        end else begin
            if (accept) begin
                cmd_read  <= bus.mem_read;
                cmd_write <= bus.mem_write;
                addr_q    <= bus.mem_addr;
                wdata_q   <= bus.mem_wdata;
                cnt       <= (lat_sel > 4'd1) ? lat_sel - 4'd2 : 4'd0;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            ack_q  <= fire;
            err_q  <= 1'b0;
            data_q <= '0;
            if (fire) begin
                if (f_wr_only) begin
                    valid[f_addr] <= 1'b1;
                end else if (f_rd_only) begin
                    if (valid[f_addr]) begin
                        data_q <= mem[f_addr];
                    end else begin
                        err_q <= 1'b1;
                    end
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Storage is not reset; words are only observable once their valid bit is set.
    always_ff @(posedge clk) begin
        if (aresetn && fire && f_wr_only) begin
            mem[f_addr] <= f_wdata;
        end
    end

    assign bus.mem_ack  = ack_q;
    assign bus.mem_err  = err_q;
    assign bus.mem_data = data_q;
    assign bus.mem_busy = (state == BUSY);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// transactions checked against a word-level memory model.
module tb_mem_responder;
    localparam int FAST = 2;
    localparam int SLOW = 9;
    localparam int DW   = 32;

    logic       clk = 1'b0;
    logic       aresetn;
    logic [7:0] drop_cnt;

    mem_responder_if #(.DATA_W(DW)) bus ();

    mem_responder #(
        .FAST_LAT(FAST),
        .SLOW_LAT(SLOW),
        .DATA_W  (DW)
    ) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [256];
    bit          ref_valid [256];
    int          ref_drop;

    function automatic int exp_lat(input logic [7:0] a);
        return (a < 8'd64) ? FAST : SLOW;
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] d);
        bus.mem_req   = 1'b1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
    endtask

    // Qualifiers carry junk while mem_req is low; the responder must ignore them.
    task automatic idle_inputs();
        bus.mem_req   = 1'b0;
        bus.mem_read  = 1'($urandom);
        bus.mem_write = 1'($urandom);
        bus.mem_addr  = 8'($urandom);
        bus.mem_wdata = $urandom;
    endtask

    task automatic reset_model();
        for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
        ref_drop = 0;
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic do_transaction(input bit rd, input bit wr, input logic [7:0] a,
                                  input logic [31:0] d, input string tag);
        int          n;
        bit          exp_err;
        logic [31:0] exp_data;
        if (wr && !rd) begin
            exp_err  = 1'b0;
            exp_data = 32'd0;
        end else if (rd && !wr) begin
            exp_err  = !ref_valid[a];
            exp_data = ref_valid[a] ? ref_mem[a] : 32'd0;
        end else begin
            exp_err  = 1'b1;
            exp_data = 32'd0;
        end
        applyStimulus(rd, wr, a, d);
        @(negedge clk);
        idle_inputs();
        checkOutput({tag, "_busy"}, 32'(bus.mem_busy), 32'd1);
        n = 1;
        while (bus.mem_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_lat"}, (bus.mem_ack === 1'b1) ? n : 0, exp_lat(a));
        checkOutput({tag, "_err"}, 32'(bus.mem_err), 32'(exp_err));
        checkOutput({tag, "_data"}, bus.mem_data, exp_data);
        if (wr && !rd) begin
            ref_mem[a]   = d;
            ref_valid[a] = 1'b1;
        end
        @(negedge clk);
        checkOutput({tag, "_end"}, {30'd0, bus.mem_ack, bus.mem_busy}, 32'd0);
    endtask

    task automatic drop_test();
        int n;
        int acks;
        applyStimulus(1'b1, 1'b0, 8'h80, 32'd0);
        @(negedge clk);
        idle_inputs();
        n = 1;
        while (n < 3) begin
            @(negedge clk);
            n++;
        end
        applyStimulus(1'b0, 1'b1, 8'h81, 32'h0BAD0BAD);
        @(negedge clk);
        n++;
        idle_inputs();
        while (n < SLOW) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t4_ack", 32'(bus.mem_ack), 32'd1);
        checkOutput("t4_err", 32'(bus.mem_err), 32'(!ref_valid[8'h80]));
        applyStimulus(1'b0, 1'b1, 8'h82, 32'h0BAD0BAD);
        @(negedge clk);
        idle_inputs();
        ref_drop = sat_add(ref_drop, 2);
        checkOutput("t4_busy", 32'(bus.mem_busy), 32'd0);
        checkOutput("t4_dropcnt", 32'(drop_cnt), ref_drop);
        acks = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.mem_ack === 1'b1) acks++;
        end
        checkOutput("t4_extra_acks", acks, 0);
        do_transaction(1'b1, 1'b0, 8'h81, 32'd0, "t4_rd81");
        do_transaction(1'b1, 1'b0, 8'h82, 32'd0, "t4_rd82");
    endtask

    task automatic reset_test();
        int acks;
        applyStimulus(1'b0, 1'b1, 8'h20, 32'hA5A5A5A5);
        @(negedge clk);
        idle_inputs();
        aresetn = 1'b0;
        reset_model();
        #1;
        checkOutput("t5_rst_ack", 32'(bus.mem_ack), 32'd0);
        checkOutput("t5_rst_busy", 32'(bus.mem_busy), 32'd0);
        checkOutput("t5_rst_err", 32'(bus.mem_err), 32'd0);
        checkOutput("t5_rst_data", bus.mem_data, 32'd0);
        checkOutput("t5_rst_drop", 32'(drop_cnt), ref_drop);
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_ack === 1'b1) acks++;
        end
        checkOutput("t5_no_ack", acks, 0);
        aresetn = 1'b1;
        @(negedge clk);
        do_transaction(1'b1, 1'b0, 8'h20, 32'd0, "t5_rd20");
    endtask

    // Holding mem_req high yields one accept per LAT+1 edges; the rest are drops.
    task automatic saturation_test();
        int acks;
        acks = 0;
        applyStimulus(1'b0, 1'b0, 8'hF0, 32'd0);
        repeat (100) begin
            @(negedge clk);
            if (bus.mem_ack === 1'b1) acks++;
        end
        checkOutput("t6_drop_100", 32'(drop_cnt), sat_add(ref_drop, 90));
        repeat (200) begin
            @(negedge clk);
            if (bus.mem_ack === 1'b1) acks++;
        end
        idle_inputs();
        repeat (15) begin
            @(negedge clk);
            if (bus.mem_ack === 1'b1) acks++;
        end
        ref_drop = sat_add(ref_drop, 270);
        checkOutput("t6_acks", acks, 30);
        checkOutput("t6_drop_sat", 32'(drop_cnt), ref_drop);
        checkOutput("t6_busy", 32'(bus.mem_busy), 32'd0);
    endtask

    initial begin
        aresetn = 1'b0;
        idle_inputs();
        reset_model();
        repeat (3) @(negedge clk);
        checkOutput("reset_ack", 32'(bus.mem_ack), 32'd0);
        checkOutput("reset_err", 32'(bus.mem_err), 32'd0);
        checkOutput("reset_data", bus.mem_data, 32'd0);
        checkOutput("reset_busy", 32'(bus.mem_busy), 32'd0);
        checkOutput("reset_drop", 32'(drop_cnt), 32'd0);
        aresetn = 1'b1;
        @(negedge clk);

        $display("[TB] fast write then read");
        do_transaction(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, "t1_wr10");
        do_transaction(1'b1, 1'b0, 8'h10, 32'd0, "t1_rd10");

        $display("[TB] slow write/read and unwritten read");
        do_transaction(1'b0, 1'b1, 8'hC8, 32'h12345678, "t2_wrC8");
        do_transaction(1'b1, 1'b0, 8'hC8, 32'd0, "t2_rdC8");
        do_transaction(1'b1, 1'b0, 8'h40, 32'd0, "t2_rd40");

        $display("[TB] illegal command");
        do_transaction(1'b1, 1'b1, 8'h05, 32'hFFFF0000, "t3_both");
        do_transaction(1'b1, 1'b0, 8'h05, 32'd0, "t3_rd05");
        do_transaction(1'b0, 1'b0, 8'h06, 32'h11110000, "t3_none");

        $display("[TB] requests while busy");
        drop_test();

        $display("[TB] reset mid-transaction");
        reset_test();

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            int          sel;
            int          pick;
            bit          rd;
            bit          wr;
            logic [7:0]  a;
            sel  = int'($urandom_range(0, 9));
            pick = int'($urandom_range(0, 2));
            rd   = (sel >= 4 && sel < 8) || sel == 8;
            wr   = (sel < 4) || sel == 8;
            if (pick == 0)      a = 8'($urandom_range(0, 7));
            else if (pick == 1) a = 8'($urandom_range(60, 67));
            else                a = 8'($urandom_range(200, 207));
            do_transaction(rd, wr, a, $urandom, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] drop counter saturation");
        saturation_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the single-cycle req/ack memory protocol (mem_req/mem_read/mem_write/mem_addr -> mem_ack/mem_err/mem_data). It holds a 256 x 32 storage array with per-word valid bits. Each accepted request is answered with exactly one single-cycle mem_ack after an address-dependent latency. It replaces the behavioural memory model behind the initiator-side benches, and its response rules match the bench SVA checks: low-address ack within 5 cycles, no error on writes, no X data on read ack.

Parameters:
FAST_LAT, 2, request-to-ack latency in cycles for mem_addr < 64; legal range 1..5
SLOW_LAT, 9, request-to-ack latency in cycles for mem_addr >= 64; legal range 1..15
DATA_W, 32, data width of mem_wdata and mem_data

Ports:
clk  input  1  clock; all logic on rising edge
aresetn  input  1  asynchronous active-low reset
mem_req  input  1  request strobe, one cycle per request
mem_read  input  1  read command, qualified by mem_req
mem_write  input  1  write command, qualified by mem_req
mem_addr  input  8  word address, qualified by mem_req
mem_wdata  input  DATA_W  write data, qualified by mem_req && mem_write
mem_ack  output  1  response strobe, exactly one cycle per accepted request
mem_err  output  1  error flag, valid only while mem_ack=1
mem_data  output  DATA_W  read data, valid only while mem_ack=1
mem_busy  output  1  a request is in flight; new requests are dropped
drop_cnt  output  8  saturating count of dropped requests

Behaviour:
- Reset (aresetn=0, async): mem_ack=0, mem_err=0, mem_data=0, mem_busy=0, drop_cnt=0, state=IDLE, all valid bits=0. Array contents are not reset.
- FSM states: IDLE and BUSY.
- IDLE, mem_req=1 (edge T):
  - Latch cmd, addr and wdata.
  - LAT = FAST_LAT if addr<64, else SLOW_LAT.
  - Go to BUSY. mem_busy=1 from the cycle after T.
- Ack timing: mem_ack is high in the cycle sampled at edge T+LAT, for exactly one cycle.
  - LAT=1: ack is registered at edge T itself, passing through BUSY for one cycle.
  - On the edge after the ack cycle: return to IDLE, mem_busy=0, mem_ack=0.
- Command decode, evaluated at ack:
  - Write only (write=1, read=0): mem[addr]<=wdata and valid[addr]<=1 at the ack edge. mem_err=0 always. mem_data=0.
  - Read only, valid[addr]=1: mem_data=mem[addr], mem_err=0.
  - Read only, valid[addr]=0: mem_data=0, mem_err=1.
  - Illegal (read=write=1, or read=write=0): mem_err=1, mem_data=0, no array or valid-bit change.
- mem_data and mem_err are 0 whenever mem_ack=0. Outputs never carry X after reset.
- mem_req=1 while state=BUSY, including the ack cycle: request dropped, no ack ever issued for it, drop_cnt+1 saturating at 255. The in-flight transaction is unaffected.
- Read-after-write to the same address: the write is committed at its ack edge, so a later read returns the new data.
- Reset mid-transaction: transaction discarded, no ack, pending write not committed, valid bits cleared.
- mem_read, mem_write, mem_addr and mem_wdata are ignored when mem_req=0.
- FAST_LAT>5 or SLOW_LAT>15 is illegal. The implementation stops elaboration with $fatal.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x10 -> mem_ack sampled high exactly 2 edges after req, mem_err=0, mem_data=0; then read 0x10 -> ack at +2, mem_data=0xDEADBEEF, mem_err=0.
- Write 0x12345678 to addr 0xC8, then read 0xC8 -> each ack exactly 9 edges after req, data 0x12345678; a read of never-written 0x40 -> ack at +9, mem_err=1, mem_data=0.
- Req with read=write=1 at addr 0x05, then read 0x05 -> first ack mem_err=1, mem_data=0; the read also returns mem_err=1 (valid bit not set).
- Addr 0x80 read in flight; issue req at +3 and a second req in the ack cycle -> one ack only, drop_cnt=2, mem_busy falls the edge after the ack.
- Start write of 0xA5A5A5A5 to 0x20; pull aresetn low at +1 -> no ack, outputs 0; after release, read 0x20 -> mem_err=1.
- 300 back-to-back requests while BUSY -> drop_cnt saturates at 255; bench SVA (addr<64 ack within 0..5, no err on write, no X on read ack) passes throughout.
